// File: rtl/vga_pkg.sv
// Shared resolution constants, the FIFO entry type and the colour-depth helper for the pixel writer.
// The active resolution is chosen at build time with VGA_RES_320x240 or VGA_RES_640x480 (default 160x120).
package vga_pkg;

`ifdef VGA_RES_640x480
    localparam int COLS = 640;
    localparam int ROWS = 480;
    localparam int nX   = 10;
    localparam int nY   = 9;
    localparam int Mn   = 19;
`elsif VGA_RES_320x240
    localparam int COLS = 320;
    localparam int ROWS = 240;
    localparam int nX   = 9;
    localparam int nY   = 8;
    localparam int Mn   = 17;
`else
    localparam int COLS = 160;
    localparam int ROWS = 120;
    localparam int nX   = 8;
    localparam int nY   = 7;
    localparam int Mn   = 15;
`endif

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [Mn-1:0] addr;
        logic [11:0]   colour;
    } pixel_wr_t;

    // Keep the top nibble of each RGB888 channel.
    function automatic logic [11:0] rgb888_to_444(input logic [23:0] c);
        return {c[23:20], c[15:12], c[7:4]};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small first-word-fall-through FIFO buffering accepted pixel writes while scan-out owns the memory port.
// Pointers wrap naturally; the count carries one extra bit so full and empty are unambiguous.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 27
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage has no reset: emptiness is defined purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vga_pixel_writer.sv
// Clips, buffers and converts the plot stream into 12-bit video memory writes,
// yielding the memory port to display scan-out whenever it requests it.
module vga_pixel_writer #(
    parameter int nX    = vga_pkg::nX,
    parameter int nY    = vga_pkg::nY,
    parameter int COLS  = vga_pkg::COLS,
    parameter int ROWS  = vga_pkg::ROWS,
    parameter int Mn    = vga_pkg::Mn,
    parameter int DEPTH = vga_pkg::DEPTH
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic [nX-1:0] VGA_X,
    input  logic [nY-1:0] VGA_Y,
    input  logic [23:0]   VGA_COLOR,
    input  logic          plot,
    output logic          in_ready,
    input  logic          scan_req,
    input  logic [Mn-1:0] scan_address,
    output logic [Mn-1:0] mem_address,
    output logic [11:0]   mem_data,
    output logic          mem_wren,
    output logic [15:0]   clip_count,
    output logic          overflow
);

    import vga_pkg::*;

    logic          in_range, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [Mn-1:0] pix_addr;
    pixel_wr_t     push_word, head_word;

    logic [Mn-1:0] mem_address_q, mem_address_d;
    logic [11:0]   mem_data_q, mem_data_d;
    logic          mem_wren_q, mem_wren_d;
    logic [15:0]   clip_count_q, clip_count_d;
    logic          overflow_q, overflow_d;

    assign in_range = (VGA_X < nX'(COLS)) && (VGA_Y < nY'(ROWS));
    // Constant multiply; synthesis reduces it to shift-add for the standard widths.
    assign pix_addr = Mn'(VGA_Y) * Mn'(COLS) + Mn'(VGA_X);

    assign push_word.addr   = pix_addr;
    assign push_word.colour = rgb888_to_444(VGA_COLOR);

    // Clipping is decided before fullness, so an off-screen pixel never counts as an overflow.
    assign fifo_push = plot && in_range && !fifo_full;
    assign fifo_pop  = !scan_req && !fifo_empty;

    pixel_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(pixel_wr_t))
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (Resetn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_word),
        .dout  (head_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        if (scan_req) begin
            mem_address_d = scan_address;
        end else if (!fifo_empty) begin
            mem_address_d = head_word.addr;
            mem_data_d    = head_word.colour;
            mem_wren_d    = 1'b1;
        end
    end

    always_comb begin
        clip_count_d = clip_count_q;
        overflow_d   = overflow_q;
        if (plot && !in_range && (clip_count_q != 16'hFFFF))
            clip_count_d = clip_count_q + 16'd1;
        if (plot && in_range && fifo_full)
            overflow_d = 1'b1;
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            clip_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            clip_count_q  <= clip_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_wren    = mem_wren_q;
    assign clip_count  = clip_count_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/vga_pixel_writer.md
Name: vga_pixel_writer

Overview:
- Downstream stage of the pixel generators: consumes the (VGA_X, VGA_Y, VGA_COLOR, plot) stream and writes pixels into the 12-bit video memory.
- Clips off-screen coordinates, buffers writes in a small FIFO, converts colour from 24-bit to 12-bit, and translates (x,y) into a linear address.
- Shares the memory port with the display scan-out, which always has priority.

Parameters:
- nX, 8, x coordinate width
- nY, 7, y coordinate width
- COLS, 160, visible columns
- ROWS, 120, visible rows
- Mn, 15, memory address width
- DEPTH, 4, FIFO entries (power of 2, ≥2)

Ports:
- CLOCK_50  in  1  system clock
- Resetn  in  1  asynchronous active-low reset
- VGA_X  in  nX  pixel column
- VGA_Y  in  nY  pixel row
- VGA_COLOR  in  24  pixel colour, RGB888
- plot  in  1  pixel valid this cycle
- in_ready  out  1  FIFO not full
- scan_req  in  1  scan-out read request, priority
- scan_address  in  Mn  scan-out read address
- mem_address  out  Mn  registered memory address
- mem_data  out  12  registered write data, RGB444
- mem_wren  out  1  registered write enable
- clip_count  out  16  saturating count of clipped pixels
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full

Behaviour:
- One clock, CLOCK_50. Resetn is asynchronous and active-low.
- Reset values: mem_address=0, mem_data=0, mem_wren=0, clip_count=0, overflow=0, FIFO empty, in_ready=1.
- Reset asserted mid-operation discards all FIFO contents immediately.
- Accept rule, sampled at each rising edge with plot=1:
  - If VGA_X≥COLS or VGA_Y≥ROWS: the pixel is discarded and clip_count increments, saturating at 16'hFFFF. Clipping is checked before fullness, so a clipped pixel never sets overflow.
  - Else if the FIFO is not full: push {addr, colour}.
  - Else: drop the pixel and set overflow=1, which stays set until reset.
- in_ready is !full, derived from the registered count.
- Push and pop in the same cycle while not full: both occur and the count is unchanged. The FIFO is never pushed when full, even if a pop occurs that cycle.
- Address: VGA_Y*COLS + VGA_X, computed at push time and truncated to Mn bits. It must be an unsigned constant multiply, or shift-add where COLS allows.
- Colour conversion: mem_data = {c[23:20], c[15:12], c[7:4]}.
- Port arbitration is evaluated each edge and registered onto the mem_* outputs:
  - scan_req=1: mem_address←scan_address, mem_wren←0, mem_data holds its value, no pop.
  - else FIFO non-empty: pop the head; mem_address←head.addr, mem_data←head.colour, mem_wren←1.
  - else: mem_wren←0; address and data hold.
- Latency: a pixel pushed at edge k into an empty FIFO with scan_req=0 appears with mem_wren=1 in the cycle after edge k+1. The write stays pending for as long as scan_req is held.
- Ordering: writes reach memory in strict acceptance order; there is no coalescing.
- Throughput: one write per cycle sustained when scan_req=0.
- Pointers: log2(DEPTH)-bit read and write pointers wrap naturally. The count is log2(DEPTH)+1 bits.

Decomposition:
- Package vga_pkg holds:
  - the resolution constants COLS, ROWS, nX, nY, Mn, selected by the resolution defines;
  - typedef pixel_wr_t {logic [Mn-1:0] addr; logic [11:0] colour;};
  - function rgb888_to_444.
- Sub-module pixel_fifo: parameterised DEPTH; ports push, pop, din, dout, full, empty; async active-low reset.
- The top level keeps the clip logic, address computation, arbitration, counters and flags.

Test Plan:
- Reset, then plot (10,5,24'hFF8040) for one cycle with scan_req=0 → two edges later mem_wren=1, mem_address=810, mem_data=12'hF84; next cycle mem_wren=0.
- plot (160,0) then (0,120) → no mem_wren pulse, clip_count=2, overflow=0.
- Hold scan_req=1 with scan_address=15'd100 and push 5 in-range pixels on consecutive cycles:
  - → mem_address=100 and mem_wren=0 throughout;
  - → in_ready=0 after the 4th push; the 5th pixel is dropped and overflow=1;
  - release scan_req → 4 consecutive mem_wren pulses in push order, then in_ready=1.
- Back-to-back plots (0,0), (159,119), (1,0) with scan_req=0 → addresses 0, 19199, 1 on consecutive cycles with no bubbles.
- Fill the FIFO to 3 entries, assert Resetn=0 asynchronously mid-cycle → outputs return to reset values at once; after release no stale writes occur and overflow=0.
- Force clip_count to 16'hFFFF via 65535 clipped plots, then clip one more → clip_count stays 16'hFFFF.
